// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - recovers hh:mm:ss from a multiplexed 7-segment scan
// Optional macro SEG_STABLE_FILTER_EN: publish a frame only when it repeats the previous valid one.
module seg_scan_decoder #(
   parameter int unsigned SETTLE      = 4,
   parameter logic [23:0] TIMEOUT     = 24'd1_000_000,
   parameter bit          SEG_ACT_LOW = 1'b1,
   parameter bit          SEL_ACT_LOW = 1'b1
) (
   input  logic       CLK_50,
   input  logic       CR,
   input  logic [7:0] hex,
   input  logic [5:0] segctrl,
   output logic [7:0] hr,
   output logic [7:0] min,
   output logic [7:0] sec,
   output logic       upd,
   output logic       seg_err,
   output logic       link_ok
);

   localparam logic [7:0]  SETTLE_W = 8'(SETTLE);
   localparam logic [7:0]  SETTLE_M1 = 8'(SETTLE - 1);
   localparam logic [23:0] TO_LAST = TIMEOUT - 24'd1;

   logic [6:0]  r_hex;
   logic [5:0]  r_sel_raw;
   logic [5:0]  r_prev_sel;
   logic [7:0]  r_cnt;
   logic [6:0]  r_digit [6];
   logic [5:0]  r_seen;
   logic        r_ok;
   logic        r_err;
   logic [23:0] r_frame;
   logic [23:0] r_to_cnt;

   logic [6:0]  w_seg;
   logic [5:0]  w_sel;
   logic        w_onehot;
   logic        w_stable;
   logic        w_capture;
   logic        w_complete;
   logic        w_pass;
   logic [4:0]  w_dec;
   logic [23:0] w_frame;
   logic        w_load;
   logic [23:0] w_to_next;
   logic        w_unused_dp;

   // dp never takes part in decoding, so it is not even registered
   assign w_unused_dp = hex[7];

   function automatic logic [4:0] f_decode(input logic [6:0] g);
      case (g)
         7'h3F:   f_decode = {1'b1, 4'd0};
         7'h06:   f_decode = {1'b1, 4'd1};
         7'h5B:   f_decode = {1'b1, 4'd2};
         7'h4F:   f_decode = {1'b1, 4'd3};
         7'h66:   f_decode = {1'b1, 4'd4};
         7'h6D:   f_decode = {1'b1, 4'd5};
         7'h7D:   f_decode = {1'b1, 4'd6};
         7'h07:   f_decode = {1'b1, 4'd7};
         7'h7F:   f_decode = {1'b1, 4'd8};
         7'h6F:   f_decode = {1'b1, 4'd9};
         default: f_decode = 5'd0;
      endcase
   endfunction

   assign w_seg      = SEG_ACT_LOW ? ~r_hex : r_hex;
   assign w_sel      = SEL_ACT_LOW ? ~r_sel_raw : r_sel_raw;
   assign w_onehot   = (w_sel != 6'd0) && ((w_sel & (w_sel - 6'd1)) == 6'd0);
   assign w_stable   = w_onehot && (w_sel == r_prev_sel);
   assign w_capture  = w_stable && (r_cnt == SETTLE_M1);
   assign w_complete = (r_seen == 6'h3F);

   // frame nibbles: [3:0] seconds units ... [23:20] hours tens
   always_comb begin
      w_pass  = 1'b1;
      w_frame = 24'd0;
      w_dec   = 5'd0;
      for (int i = 0; i < 6; i++) begin
         w_dec = f_decode(r_digit[i]);
         w_frame[i*4 +: 4] = w_dec[3:0];
         if (!w_dec[4]) w_pass = 1'b0;
      end
      if (w_frame[23:20] > 4'd2 || (w_frame[23:20] == 4'd2 && w_frame[19:16] > 4'd3)) w_pass = 1'b0;
      if (w_frame[15:12] > 4'd5) w_pass = 1'b0;
      if (w_frame[7:4] > 4'd5) w_pass = 1'b0;
   end

   always_ff @(posedge CLK_50 or posedge CR) begin
      if (CR) begin
         r_hex      <= 7'd0;
         r_sel_raw  <= 6'd0;
         r_prev_sel <= 6'd0;
         r_cnt      <= 8'd0;
         r_seen     <= 6'd0;
         r_ok       <= 1'b0;
         r_err      <= 1'b0;
         r_frame    <= 24'd0;
         for (int i = 0; i < 6; i++) r_digit[i] <= 7'd0;
      end else begin
         r_hex      <= hex[6:0];
         r_sel_raw  <= segctrl;
         r_prev_sel <= w_sel;
         if (!w_stable) r_cnt <= 8'd0;
         else if (r_cnt != SETTLE_W) r_cnt <= r_cnt + 8'd1;
         for (int i = 0; i < 6; i++) begin
            if (w_capture && w_sel[i]) r_digit[i] <= w_seg;
         end
         r_seen  <= (w_complete ? 6'd0 : r_seen) | (w_capture ? w_sel : 6'd0);
         r_ok    <= w_complete && w_pass;
         r_err   <= w_complete && !w_pass;
         if (w_complete) r_frame <= w_frame;
      end
   end

`ifdef SEG_STABLE_FILTER_EN
   logic [23:0] r_prev_frame;
   logic        r_prev_valid;

   assign w_load = r_ok && r_prev_valid && (r_prev_frame == r_frame);

   always_ff @(posedge CLK_50 or posedge CR) begin
      if (CR) begin
         r_prev_frame <= 24'd0;
         r_prev_valid <= 1'b0;
      end else if (r_ok) begin
         r_prev_frame <= r_frame;
         r_prev_valid <= 1'b1;
      end
   end
`else
   assign w_load = r_ok;
`endif

   assign w_to_next = (r_to_cnt == TO_LAST) ? r_to_cnt : r_to_cnt + 24'd1;

   always_ff @(posedge CLK_50 or posedge CR) begin
      if (CR) begin
         hr       <= 8'h00;
         min      <= 8'h00;
         sec      <= 8'h00;
         upd      <= 1'b0;
         seg_err  <= 1'b0;
         link_ok  <= 1'b0;
         r_to_cnt <= 24'd0;
      end else begin
         upd     <= w_load;
         seg_err <= r_err;
         if (w_load) {hr, min, sec} <= r_frame;
         // an accepted frame (filter-held or not) always wins over expiry
         if (r_ok) begin
            r_to_cnt <= 24'd0;
            link_ok  <= 1'b1;
         end else begin
            r_to_cnt <= w_to_next;
            if (w_to_next == TO_LAST) link_ok <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - self-checking bench for seg_scan_decoder
module tb_seg_scan_decoder;

   localparam int          SETTLE  = 4;
   localparam logic [23:0] TIMEOUT = 24'd300;
   localparam int          DWELL   = 10;

   logic       CLK_50 = 1'b0;
   logic       CR = 1'b1;
   logic [7:0] hex = 8'hFF;
   logic [5:0] segctrl = 6'h3F;
   logic [7:0] hr, min, sec;
   logic       upd, seg_err, link_ok;

   seg_scan_decoder #(
      .SETTLE(SETTLE), .TIMEOUT(TIMEOUT), .SEG_ACT_LOW(1'b1), .SEL_ACT_LOW(1'b1)
   ) dut (
      .CLK_50(CLK_50), .CR(CR), .hex(hex), .segctrl(segctrl),
      .hr(hr), .min(min), .sec(sec), .upd(upd), .seg_err(seg_err), .link_ok(link_ok)
   );

   always #5 CLK_50 = ~CLK_50;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int n_upd = 0, n_err = 0, n_both = 0;
   int upd_cyc = -1;
   int c_last = 0;

   logic [6:0] gly [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   always @(posedge CLK_50) cyc <= cyc + 1;

   always @(negedge CLK_50) begin
      if (upd) begin
         n_upd   <= n_upd + 1;
         upd_cyc <= cyc;
      end
      if (seg_err) n_err <= n_err + 1;
      if (upd && seg_err) n_both <= n_both + 1;
   end

   typedef struct {
      logic [41:0] f;
      int          eu;
      int          ee;
      logic [7:0]  h, m, s;
   } vec_t;

   vec_t tbl [8];

   function automatic int glyph_val(input logic [6:0] g);
      for (int i = 0; i < 10; i++) if (gly[i] == g) return i;
      return -1;
   endfunction

   function automatic logic [41:0] mk(input int h10, h1, m10, m1, s10, s1);
      return {gly[h10], gly[h1], gly[m10], gly[m1], gly[s10], gly[s1]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive_raw(input logic [5:0] sel_hi, input logic [6:0] g, input int cycles);
      segctrl = ~sel_hi;
      hex     = ~{1'($urandom_range(0, 1)), g};
      repeat (cycles) @(negedge CLK_50);
   endtask

   task automatic blank(input int n);
      segctrl = 6'h3F;
      hex     = 8'hFF;
      repeat (n) @(negedge CLK_50);
   endtask

   task automatic scan(input logic [41:0] f);
      for (int i = 0; i < 6; i++) begin
         if (i == 5) c_last = cyc;
         drive_raw(6'b1 << i, f[i*7 +: 7], DWELL);
      end
      blank(8);
   endtask

   task automatic run_frame(input string name, input logic [41:0] f, input int eu, input int ee,
                            input logic [7:0] eh, input logic [7:0] em, input logic [7:0] es);
      int u0, e0;
      u0 = n_upd;
      e0 = n_err;
      scan(f);
      check({name, " upd"}, n_upd - u0, eu);
      check({name, " seg_err"}, n_err - e0, ee);
      check({name, " hr"}, hr, eh);
      check({name, " min"}, min, em);
      check({name, " sec"}, sec, es);
   endtask

   task automatic scan_accept(input string name, input logic [41:0] f,
                              input logic [7:0] eh, input logic [7:0] em, input logic [7:0] es);
`ifdef SEG_STABLE_FILTER_EN
      scan(f);
`endif
      run_frame(name, f, 1, 0, eh, em, es);
   endtask

   initial begin
      logic [41:0] f;
      int d [6];
      logic [6:0] g;
      logic ok;
      logic [7:0] mh, mm, ms;
      int u0, e0, c0, acc;

      tbl[0] = '{mk(1,2,3,4,5,6), 1, 0, 8'h12, 8'h34, 8'h56};
      f = mk(1,2,3,4,5,6); f[20:14] = 7'h27;
      tbl[1] = '{f, 0, 1, 8'h12, 8'h34, 8'h56};
      tbl[2] = '{mk(2,4,0,0,0,0), 0, 1, 8'h12, 8'h34, 8'h56};
      tbl[3] = '{mk(2,3,5,9,5,9), 1, 0, 8'h23, 8'h59, 8'h59};
      tbl[4] = '{mk(0,9,0,8,0,7), 1, 0, 8'h09, 8'h08, 8'h07};
      tbl[5] = '{mk(0,0,6,0,0,0), 0, 1, 8'h09, 8'h08, 8'h07};
      tbl[6] = '{mk(2,0,0,0,6,0), 0, 1, 8'h09, 8'h08, 8'h07};
      tbl[7] = '{mk(0,0,0,0,0,0), 1, 0, 8'h00, 8'h00, 8'h00};

      repeat (3) @(negedge CLK_50);
      check("reset hr", hr, 8'h00);
      check("reset min", min, 8'h00);
      check("reset sec", sec, 8'h00);
      check("reset upd", upd, 1'b0);
      check("reset seg_err", seg_err, 1'b0);
      check("reset link_ok", link_ok, 1'b0);
      CR = 1'b0;
      @(negedge CLK_50);

`ifndef SEG_STABLE_FILTER_EN
      for (int i = 0; i < 8; i++) begin
         run_frame($sformatf("tbl%0d", i), tbl[i].f, tbl[i].eu, tbl[i].ee, tbl[i].h, tbl[i].m, tbl[i].s);
         if (i == 0) check("tbl0 link_ok", link_ok, 1'b1);
      end

      // completing capture to upd: input register, select-change cycle, SETTLE, then 2
      f = mk(0,7,1,2,3,4);
      for (int i = 0; i < 5; i++) drive_raw(6'b1 << i, f[i*7 +: 7], DWELL);
      c0 = cyc;
      drive_raw(6'b100000, f[41:35], DWELL);
      blank(4);
      check("latency", upd_cyc - c0, SETTLE + 4);
      check("latency hr", hr, 8'h07);

      mh = hr; mm = min; ms = sec;
      for (int n = 0; n < 24; n++) begin
         d[5] = $urandom_range(0, 2); d[4] = $urandom_range(0, 9);
         d[3] = $urandom_range(0, 6); d[2] = $urandom_range(0, 9);
         d[1] = $urandom_range(0, 6); d[0] = $urandom_range(0, 9);
         f = mk(d[5], d[4], d[3], d[2], d[1], d[0]);
         for (int i = 0; i < 6; i++) begin
            if ($urandom_range(0, 9) == 0) begin
               g = 7'($urandom_range(0, 127));
               while (glyph_val(g) >= 0) g = 7'($urandom_range(0, 127));
               f[i*7 +: 7] = g;
            end
         end
         ok = 1'b1;
         for (int i = 0; i < 6; i++) begin
            d[i] = glyph_val(f[i*7 +: 7]);
            if (d[i] < 0) ok = 1'b0;
         end
         if (ok && (d[5] * 10 + d[4] > 23 || d[3] > 5 || d[1] > 5)) ok = 1'b0;
         if (ok) begin
            mh = 8'(d[5] * 16 + d[4]);
            mm = 8'(d[3] * 16 + d[2]);
            ms = 8'(d[1] * 16 + d[0]);
         end
         run_frame($sformatf("rnd%0d", n), f, ok ? 1 : 0, ok ? 0 : 1, mh, mm, ms);
      end
      run_frame("pre_reset", mk(1,1,1,1,1,1), 1, 0, 8'h11, 8'h11, 8'h11);
`else
      run_frame("flt_a", mk(0,1,0,2,0,3), 0, 0, 8'h00, 8'h00, 8'h00);
      run_frame("flt_b", mk(0,1,0,2,0,4), 0, 0, 8'h00, 8'h00, 8'h00);
      run_frame("flt_c", mk(0,1,0,2,0,4), 1, 0, 8'h01, 8'h02, 8'h04);
      check("flt link_ok", link_ok, 1'b1);
`endif

      // asynchronous reset in the middle of a frame
      f = mk(1,5,4,2,3,7);
      for (int i = 0; i < 3; i++) drive_raw(6'b1 << i, f[i*7 +: 7], DWELL);
      #2 CR = 1'b1;
      #1;
      check("async hr", hr, 8'h00);
      check("async min", min, 8'h00);
      check("async sec", sec, 8'h00);
      check("async link_ok", link_ok, 1'b0);
      @(negedge CLK_50);
      CR = 1'b0;
      u0 = n_upd; e0 = n_err;
      for (int i = 3; i < 6; i++) drive_raw(6'b1 << i, f[i*7 +: 7], DWELL);
      blank(8);
      check("partial discard upd", n_upd - u0, 0);
      check("partial discard err", n_err - e0, 0);
      scan_accept("post_reset", f, 8'h15, 8'h42, 8'h37);

      // short dwell and two-hot select never capture
      CR = 1'b1;
      @(negedge CLK_50);
      CR = 1'b0;
      f = mk(0,3,0,3,0,3);
      u0 = n_upd; e0 = n_err;
      for (int i = 0; i < 5; i++) drive_raw(6'b1 << i, f[i*7 +: 7], DWELL);
      drive_raw(6'b100000, f[41:35], 3);
      blank(8);
      check("short dwell upd", n_upd - u0, 0);
      check("short dwell err", n_err - e0, 0);
      drive_raw(6'b100001, f[41:35], DWELL);
      blank(8);
      check("two-hot upd", n_upd - u0, 0);
      check("two-hot err", n_err - e0, 0);

      // link loss after TIMEOUT idle cycles
      CR = 1'b1;
      @(negedge CLK_50);
      CR = 1'b0;
      f = mk(2,2,2,2,2,2);
`ifdef SEG_STABLE_FILTER_EN
      scan(f);
`endif
      scan(f);
      acc = c_last + SETTLE + 4;
      check("timeout link up", link_ok, 1'b1);
      while (cyc < acc + int'(TIMEOUT) - 3) @(negedge CLK_50);
      check("timeout before", link_ok, 1'b1);
      while (cyc < acc + int'(TIMEOUT) + 2) @(negedge CLK_50);
      check("timeout after", link_ok, 1'b0);

      check("upd with seg_err", n_both, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter SETTLE, default 4: cycles a digit select must hold before its segments are captured (range 1..255).
REQ-002 SHALL have parameter TIMEOUT, default 24'd1_000_000: cycles without an accepted frame before the link is declared lost.
REQ-003 SHALL have parameter SEG_ACT_LOW, default 1: segment inputs are active-low when 1.
REQ-004 SHALL have parameter SEL_ACT_LOW, default 1: digit-select inputs are active-low when 1.
REQ-005 SHALL have port CLK_50, input, 1 bit: the only clock, rising edge.
REQ-006 SHALL have port CR, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL have port hex, input, 8 bits: multiplexed segments {dp,g,f,e,d,c,b,a}.
REQ-008 SHALL have port segctrl, input, 6 bits: digit select. Bit 0 is seconds units, 1 seconds tens, 2 minutes units, 3 minutes tens, 4 hours units, 5 hours tens.
REQ-009 SHALL have port hr, output, 8 bits: decoded hours, packed BCD.
REQ-010 SHALL have port min, output, 8 bits: decoded minutes, packed BCD.
REQ-011 SHALL have port sec, output, 8 bits: decoded seconds, packed BCD.
REQ-012 SHALL have port upd, output, 1 bit: one-cycle pulse when hr/min/sec are updated.
REQ-013 SHALL have port seg_err, output, 1 bit: one-cycle pulse when a complete frame is rejected.
REQ-014 SHALL have port link_ok, output, 1 bit: level, high while frames keep arriving within TIMEOUT.

Function
REQ-015 SHALL register hex and segctrl once, then normalise both to active-high according to SEG_ACT_LOW and SEL_ACT_LOW.
REQ-016 SHALL clear the settle counter whenever the normalised select changes, is all-zero, or has more than one bit set, and SHALL capture nothing in those cycles.
REQ-017 SHALL capture hex[6:0] into the selected digit slot exactly once per select dwell: on the cycle the settle counter reaches SETTLE.
REQ-018 SHALL set that digit's bit in a 6-bit seen-mask on capture; a digit re-captured before the frame completes SHALL overwrite its slot (latest wins).
REQ-019 SHALL ignore dp (hex[7]) in all decoding and comparisons.
REQ-020 SHALL mark a frame complete when the seen-mask reaches 6'b111111, evaluate it in the following cycle, and clear the mask in that same cycle.
REQ-021 SHALL decode glyphs (g..a, active-high) as 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9; any other pattern is invalid.
REQ-022 SHALL reject a frame if any glyph is invalid, hours > 23, minutes tens > 5, or seconds tens > 5.
REQ-023 SHALL, on rejection, pulse seg_err for one cycle and leave hr/min/sec and upd unchanged.
REQ-024 SHALL, on acceptance, load hr/min/sec and pulse upd in the same cycle; latency from the completing capture to upd is 2 cycles.
REQ-025 SHALL restart the timeout counter on every accepted frame; link_ok is set on acceptance and cleared when the counter reaches TIMEOUT-1.
REQ-026 SHALL hold the timeout counter at TIMEOUT-1 once there, with no wrap-around.
REQ-027 SHALL give precedence to acceptance when acceptance and timeout expiry occur in the same cycle: link_ok stays 1.
REQ-028 SHALL never assert upd and seg_err in the same cycle.

Reset
REQ-029 SHALL, while CR=1, immediately force: hr=min=sec=8'h00; upd=0; seg_err=0; link_ok=0; seen-mask, settle counter and timeout counter cleared; previous-frame register cleared, with its valid flag set to 0.
REQ-030 SHALL discard a partially captured frame on reset; capture restarts from an empty mask after CR falls.

Configuration
REQ-031 SHALL provide the macro SEG_STABLE_FILTER_EN.
REQ-032 SHALL, when SEG_STABLE_FILTER_EN is defined, store every frame that passes REQ-022, and load outputs and pulse upd only when that frame equals the previously stored valid frame; the first valid frame after reset only primes the store. Filter-held frames SHALL still count as accepted for link_ok and the timeout restart.
REQ-033 SHALL, when SEG_STABLE_FILTER_EN is undefined, update outputs on every frame that passes REQ-022; no previous-frame register is built.

Verification
REQ-034 Scan 12:34:56 active-low with 10-cycle dwell per digit, filter off -> upd once; hr=8'h12, min=8'h34, sec=8'h56; link_ok=1.
REQ-035 Same scan, minutes-units glyph 7'h27 -> seg_err pulse; outputs stay 12:34:56 from the prior frame; no upd.
REQ-036 Scan 24:00:00 -> seg_err pulse; 23:59:59 -> upd with hr=8'h23, min=8'h59, sec=8'h59.
REQ-037 Select held only 3 cycles (SETTLE=4), or a two-hot select -> no capture, and no frame completes.
REQ-038 Filter on, frames 01:02:03 then 01:02:04 then 01:02:04 -> upd only on the third frame.
REQ-039 Scan stops for TIMEOUT cycles -> link_ok falls; CR pulse mid-frame -> all outputs 0 asynchronously and the next full frame decodes correctly.
